addsub_pipe: RTL and testbench

Parametrised, two-stage pipelined integer add/subtract/compare unit for the execute path, with a valid/ready handshake on both sides. It generalises the fixed 32-bit lookahead subtractor in three ways: a width parameter, an opcode-selected mode (signed/unsigned add, subtract, set-less-than), and registered flags. The low half is computed in stage 1 and the high half plus flags in stage 2, which shortens the carry path. A flush input discards in-flight operations on exceptions or branch redirects.

---
 rtl/addsub_pipe_if.sv | 27 ++
 rtl/addsub_pipe.sv | 190 +++++++++++++++++++
 tb/tb_addsub_pipe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_if.sv
// Operand/result bus of the add/subtract/compare unit: valid/ready on both sides.
// The unit itself connects through the slave modport; the producer/consumer uses master.
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, ovf, carry, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, ovf, carry, zero
  );
endinterface

// File: rtl/addsub_pipe.sv
// Two-stage add/sub/compare unit: low-half sum in stage 1, high half plus flags in stage 2.
// Each half uses GROUP-bit carry-lookahead blocks with a second-level group lookahead.
module addsub_pipe_cla #(
  parameter int N     = 16,
  parameter int GROUP = 4
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  localparam int NG = N / GROUP;

  logic [N-1:0]  g, p;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;

  assign g = x_i & y_i;
  assign p = x_i ^ y_i;

  always_comb begin
    gg = '0;
    gp = '1;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        gg[k] = g[k*GROUP+i] | (p[k*GROUP+i] & gg[k]);
        gp[k] = gp[k] & p[k*GROUP+i];
      end
    end
  end

  // Each group carry is a flat sum of products of group G/P terms and cin.
  always_comb begin
    logic c, t;
    gc = '0;
    gc[0] = cin_i;
    for (int k = 1; k <= NG; k++) begin
      t = cin_i;
      for (int m = 0; m < k; m++) t = t & gp[m];
      c = t;
      for (int j = 0; j < k; j++) begin
        t = gg[j];
        for (int m = j + 1; m < k; m++) t = t & gp[m];
        c = c | t;
      end
      gc[k] = c;
    end
  end

  always_comb begin
    logic c;
    sum_o = '0;
    for (int k = 0; k < NG; k++) begin
      c = gc[k];
      for (int i = 0; i < GROUP; i++) begin
        sum_o[k*GROUP+i] = p[k*GROUP+i] ^ c;
        c = g[k*GROUP+i] | (p[k*GROUP+i] & c);
      end
    end
  end

  assign cout_o = gc[NG];
endmodule

module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  addsub_pipe_if.slave bus
);
  localparam int H = WIDTH / 2;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;

  function automatic logic is_sub(input logic [2:0] o);
    return (o[2:1] == 2'b01) || (o[2:1] == 2'b10);
  endfunction

  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic             s1_adv, s2_adv, in_ready, in_fire;
  logic [H-1:0]     s1_sum_lo_q, s1_a_hi_q, s1_b_hi_q;
  logic             s1_clo_q;
  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d, carry_q, carry_d, zero_q, zero_d;

  // handshake
  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !flush && !reset;
  assign in_fire  = bus.in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_adv ? in_fire : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // stage 1: operand conditioning and low-half sum
  logic             sub_in, c_lo;
  logic [WIDTH-1:0] b_eff;
  logic [H-1:0]     sum_lo;

  assign sub_in = is_sub(bus.op);
  assign b_eff  = sub_in ? ~bus.b : bus.b;

  addsub_pipe_cla #(.N(H), .GROUP(GROUP)) u_lo (
    .x_i   (bus.a[H-1:0]),
    .y_i   (b_eff[H-1:0]),
    .cin_i (sub_in),
    .sum_o (sum_lo),
    .cout_o(c_lo)
  );

  // stage 2: high-half sum and flags
  logic [H-1:0] sum_hi;
  logic         c_out, ex, ex_ovf;

  addsub_pipe_cla #(.N(H), .GROUP(GROUP)) u_hi (
    .x_i   (s1_a_hi_q),
    .y_i   (s1_b_hi_q),
    .cin_i (s1_clo_q),
    .sum_o (sum_hi),
    .cout_o(c_out)
  );

  // ex is bit W of the sign-extended sum; it differs from bit W-1 exactly on overflow
  assign ex     = s1_a_hi_q[H-1] ^ s1_b_hi_q[H-1] ^ c_out;
  assign ex_ovf = ex ^ sum_hi[H-1];

  always_comb begin
    result_d = {sum_hi, s1_sum_lo_q};
    case (s1_op_q)
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, sum_hi[H-1] ^ ex_ovf};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, ~c_out};
      default: ;
    endcase
    ovf_d   = ex_ovf && (s1_op_q == OP_ADD || s1_op_q == OP_SUB);
    carry_d = c_out ^ is_sub(s1_op_q);
    zero_d  = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_sum_lo_q <= '0;
      s1_clo_q    <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_b_hi_q   <= '0;
      s1_op_q     <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_sum_lo_q <= sum_lo;
        s1_clo_q    <= c_lo;
        s1_a_hi_q   <= bus.a[WIDTH-1:H];
        s1_b_hi_q   <= b_eff[WIDTH-1:H];
        s1_op_q     <= bus.op;
      end
      if (s1_valid_q && s2_adv) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        carry_q  <= carry_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: a 32-bit and a 16-bit instance driven in lockstep,
// expected values worked out by hand for each vector.
module tb_addsub_pipe;
  localparam logic [2:0] ADD  = 3'b000, ADDU = 3'b001, SUB = 3'b010, SUBU = 3'b011;
  localparam logic [2:0] SLT  = 3'b100, SLTU = 3'b101, RSVD = 3'b110;

  logic clk = 1'b0;
  logic reset, flush;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(32)) b32();
  addsub_pipe_if #(.WIDTH(16)) b16();

  addsub_pipe #(.WIDTH(32), .GROUP(4)) u32 (.clk(clk), .reset(reset), .flush(flush), .bus(b32));
  addsub_pipe #(.WIDTH(16), .GROUP(4)) u16 (.clk(clk), .reset(reset), .flush(flush), .bus(b16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [15:0] a16, input logic [15:0] b16v);
    b32.in_valid = v; b32.op = o; b32.a = a;   b32.b = b;
    b16.in_valid = v; b16.op = o; b16.a = a16; b16.b = b16v;
  endtask

  task automatic rdy(input logic r);
    b32.out_ready = r;
    b16.out_ready = r;
  endtask

  task automatic op32(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic ov, input logic cy, input logic z);
    put(1'b1, o, a, b, a[15:0], b[15:0]);
    rdy(1'b1);
    #1;
    chk1({tag, ".in_ready"}, b32.in_ready, 1'b1);
    step();
    put(1'b0, ADD, 32'd0, 32'd0, 16'd0, 16'd0);
    #1;
    chk1({tag, ".lat1"}, b32.out_valid, 1'b0);
    step();
    chk1({tag, ".valid"}, b32.out_valid, 1'b1);
    chk ({tag, ".result"}, b32.result, res);
    chk1({tag, ".ovf"}, b32.ovf, ov);
    chk1({tag, ".carry"}, b32.carry, cy);
    chk1({tag, ".zero"}, b32.zero, z);
    step();
    chk1({tag, ".drained"}, b32.out_valid, 1'b0);
  endtask

  task automatic op16(input string tag, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] res, input logic ov, input logic cy, input logic z);
    put(1'b1, o, 32'd0, 32'd0, a, b);
    rdy(1'b1);
    step();
    put(1'b0, ADD, 32'd0, 32'd0, 16'd0, 16'd0);
    step();
    chk1({tag, ".valid"}, b16.out_valid, 1'b1);
    chk ({tag, ".result"}, 32'(b16.result), 32'(res));
    chk1({tag, ".ovf"}, b16.ovf, ov);
    chk1({tag, ".carry"}, b16.carry, cy);
    chk1({tag, ".zero"}, b16.zero, z);
    step();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    put(1'b0, ADD, 32'd0, 32'd0, 16'd0, 16'd0);
    rdy(1'b0);
    step();
    step();
    chk1("rst.in_ready32", b32.in_ready, 1'b0);
    chk1("rst.in_ready16", b16.in_ready, 1'b0);
    chk1("rst.valid32", b32.out_valid, 1'b0);
    chk ("rst.result32", b32.result, 32'h0);
    chk1("rst.zero32", b32.zero, 1'b0);
    chk1("rst.valid16", b16.out_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rst.release_ready", b32.in_ready, 1'b1);

    // 32-bit arithmetic vectors
    op32("add_ovf",   ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0);
    op32("subu_brw",  SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    op32("sub_ovf",   SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    op32("addu_wrap", ADDU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1);
    op32("add_cy",    ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
    op32("addu_mid",  ADDU, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0);
    op32("subu_mid",  SUBU, 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    op32("slt_neg",   SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    op32("sltu_ge",   SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1);
    op32("slt_ovf",   SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    op32("sltu_lt",   SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0);
    op32("rsvd",      RSVD, 32'h00000005, 32'h00000006, 32'h0000000B, 1'b0, 1'b0, 1'b0);

    // 16-bit vectors
    op16("w16_add_ovf", ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0);
    op16("w16_subu",    SUBU, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0);

    // backpressure: out_ready low for three cycles, four ADDU (i,i)
    rdy(1'b0);
    put(1'b1, ADDU, 32'd1, 32'd1, 16'd1, 16'd1);
    #1;
    chk1("bp.c0_ready", b32.in_ready, 1'b1);
    step();
    put(1'b1, ADDU, 32'd2, 32'd2, 16'd2, 16'd2);
    #1;
    chk1("bp.c1_ready", b32.in_ready, 1'b1);
    step();
    put(1'b1, ADDU, 32'd3, 32'd3, 16'd3, 16'd3);
    #1;
    chk1("bp.c2_ready", b32.in_ready, 1'b0);
    chk1("bp.c2_ready16", b16.in_ready, 1'b0);
    chk1("bp.c2_valid", b32.out_valid, 1'b1);
    chk ("bp.c2_result", b32.result, 32'd2);
    step();
    rdy(1'b1);
    #1;
    chk1("bp.c3_ready", b32.in_ready, 1'b1);
    chk ("bp.c3_hold", b32.result, 32'd2);
    step();
    put(1'b1, ADDU, 32'd4, 32'd4, 16'd4, 16'd4);
    #1;
    chk1("bp.c4_valid", b32.out_valid, 1'b1);
    chk ("bp.c4_result", b32.result, 32'd4);
    step();
    put(1'b0, ADD, 32'd0, 32'd0, 16'd0, 16'd0);
    #1;
    chk ("bp.c5_result", b32.result, 32'd6);
    chk ("bp.c5_result16", 32'(b16.result), 32'd6);
    step();
    chk1("bp.c6_valid", b32.out_valid, 1'b1);
    chk ("bp.c6_result", b32.result, 32'd8);
    step();
    chk1("bp.c7_empty", b32.out_valid, 1'b0);

    // flush with two ops in flight and a third presented during flush
    rdy(1'b0);
    put(1'b1, ADDU, 32'd3, 32'd4, 16'd3, 16'd4);
    step();
    put(1'b1, ADDU, 32'd5, 32'd6, 16'd5, 16'd6);
    step();
    put(1'b1, ADDU, 32'd7, 32'd8, 16'd7, 16'd8);
    flush = 1'b1;
    #1;
    chk1("fl.ready32", b32.in_ready, 1'b0);
    chk1("fl.ready16", b16.in_ready, 1'b0);
    step();
    flush = 1'b0;
    put(1'b0, ADD, 32'd0, 32'd0, 16'd0, 16'd0);
    rdy(1'b1);
    #1;
    chk1("fl.c1_valid32", b32.out_valid, 1'b0);
    chk1("fl.c1_valid16", b16.out_valid, 1'b0);
    step();
    chk1("fl.c2_valid32", b32.out_valid, 1'b0);
    chk1("fl.c2_valid16", b16.out_valid, 1'b0);
    step();
    chk1("fl.c3_valid32", b32.out_valid, 1'b0);
    chk1("fl.c3_valid16", b16.out_valid, 1'b0);

    // reset mid-stream with a flagged result on the outputs
    rdy(1'b0);
    put(1'b1, ADD, 32'h7FFFFFFF, 32'h1, 16'h7FFF, 16'h1);
    step();
    step();
    chk1("rs.pre_valid32", b32.out_valid, 1'b1);
    chk1("rs.pre_ovf32", b32.ovf, 1'b1);
    chk ("rs.pre_result16", 32'(b16.result), 32'h8000);
    chk1("rs.pre_ovf16", b16.ovf, 1'b1);
    reset = 1'b1;
    put(1'b0, ADD, 32'd0, 32'd0, 16'd0, 16'd0);
    #1;
    chk1("rs.ready_in_reset", b32.in_ready, 1'b0);
    step();
    chk1("rs.valid32", b32.out_valid, 1'b0);
    chk ("rs.result32", b32.result, 32'h0);
    chk1("rs.ovf32", b32.ovf, 1'b0);
    chk1("rs.carry32", b32.carry, 1'b0);
    chk1("rs.zero32", b32.zero, 1'b0);
    chk1("rs.valid16", b16.out_valid, 1'b0);
    chk ("rs.result16", 32'(b16.result), 32'h0);
    chk1("rs.ovf16", b16.ovf, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rs.ready_after32", b32.in_ready, 1'b1);
    chk1("rs.ready_after16", b16.in_ready, 1'b1);
    step();
    chk1("rs.drained32", b32.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
